// File: rtl/mem_apb_pkg.sv
// Shared definitions for the APB wait-state slave memory: FSM states, sizing helper
// and the address error check used by the decoder.
`ifndef MEM_APB_ADDR_ERR
`define MEM_APB_ADDR_ERR(off, addr, size) (((off) >= (size)) || ((addr[1:0]) != 2'b00))
`endif

package mem_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    localparam int CNT_W = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_apb_ram.sv
// Single-port word RAM with per-byte write enables and asynchronous read.
// Latency: write lands on the clock edge, read is combinational; no backpressure.
module mem_apb_ram
    import mem_apb_pkg::*;
#(
    parameter int P_DEPTH  = 256,
    parameter int P_DWIDTH = 32,
    parameter int P_STRB   = P_DWIDTH / 8,
    parameter int P_AW     = clog2(P_DEPTH)
) (
    input  logic                PCLK,
    input  logic                we,
    input  logic [P_AW-1:0]     addr,
    input  logic [P_DWIDTH-1:0] wdata,
    input  logic [P_STRB-1:0]   be,
    output logic [P_DWIDTH-1:0] rdata
);

    logic [P_DWIDTH-1:0] mem [P_DEPTH];

    // Contents are deliberately not reset; software writes before it reads.
    always_ff @(posedge PCLK) begin
        if (we) begin
            for (int i = 0; i < P_STRB; i++) begin
                if (be[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_apb_wait.sv
// APB3/APB4 slave memory with byte-lane writes, P_DELAY wait states and PSLVERR on bad addresses.
// Latency: PREADY in access cycle P_DELAY+1; backpressure: wait states are driven through PREADY.
module mem_apb_wait
    import mem_apb_pkg::*;
#(
    parameter int          P_DWIDTH        = 32,
    parameter int          P_STRB          = P_DWIDTH / 8,
    parameter int          P_SIZE_IN_BYTES = 1024,
    parameter logic [31:0] P_ADDR_START    = 32'h0000_0000,
    parameter int          P_DELAY         = 0
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                PSEL,
    input  logic [31:0]         PADDR,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [P_DWIDTH-1:0] PWDATA,
    input  logic [P_STRB-1:0]   PSTRB,
    input  logic [2:0]          PPROT,
    output logic [P_DWIDTH-1:0] PRDATA,
    output logic                PREADY,
    output logic                PSLVERR
);

    localparam int AW    = clog2(P_SIZE_IN_BYTES);
    localparam int IW    = AW - 2;
    localparam int DEPTH = P_SIZE_IN_BYTES / 4;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [31:0]         off;
    logic                addr_err;
    logic [IW-1:0]       idx;
    logic [P_DWIDTH-1:0] rd_dat;
    logic [P_DWIDTH-1:0] rd_resp;
    logic                wr_en;
    logic                unused_prot;

    assign unused_prot = ^PPROT;

    // Addresses below the base wrap to a huge offset and fall into the range error.
    assign off      = PADDR - P_ADDR_START;
    assign addr_err = `MEM_APB_ADDR_ERR(off, PADDR, 32'(P_SIZE_IN_BYTES));
    assign idx      = off[AW-1:2];
    assign rd_resp  = (addr_err || PWRITE) ? '0 : rd_dat;

    assign wr_en = (state == ST_READY) && PSEL && PENABLE && PREADY && PWRITE && !PSLVERR;

    mem_apb_ram #(
        .P_DEPTH  (DEPTH),
        .P_DWIDTH (P_DWIDTH),
        .P_STRB   (P_STRB),
        .P_AW     (IW)
    ) u_ram (
        .PCLK  (PCLK),
        .we    (wr_en),
        .addr  (idx),
        .wdata (PWDATA),
        .be    (PSTRB),
        .rdata (rd_dat)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // PENABLE without a preceding setup phase is not a transfer.
                    if (PSEL && !PENABLE) begin
                        cnt <= CNT_W'(P_DELAY);
                        if (P_DELAY == 0) begin
                            state   <= ST_READY;
                            PREADY  <= 1'b1;
                            PSLVERR <= addr_err;
                            PRDATA  <= rd_resp;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!PSEL) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (PENABLE) begin
                        if (cnt <= CNT_W'(1)) begin
                            state   <= ST_READY;
                            cnt     <= '0;
                            PREADY  <= 1'b1;
                            PSLVERR <= addr_err;
                            PRDATA  <= rd_resp;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                ST_READY: begin
                    state   <= ST_IDLE;
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    PRDATA  <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_apb_wait.sv
// Four slaves (delays 0,2,3,5) on separate PSEL bits, checked against a word-array model.
module tb_mem_apb_wait;

    logic        pclk;
    logic        prst_n;
    logic [3:0]  psel;
    logic [31:0] paddr;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata [4];
    logic        pready [4];
    logic        pslverr[4];

    int          n_cmp = 0;
    int          n_bad = 0;

    int          dly [4]  = '{0, 2, 3, 5};
    logic [31:0] base[4]  = '{32'h0000_0000, 32'h0000_0400, 32'h0000_0800, 32'h0000_0C00};
    localparam int SIZE   = 1024;

    logic [31:0] mem_m [4][256];
    bit          known [4][256];

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    mem_apb_wait #(.P_ADDR_START(32'h0000_0000), .P_DELAY(0)) u_s0 (
        .PCLK(pclk), .PRESETn(prst_n), .PSEL(psel[0]), .PADDR(paddr), .PENABLE(penable),
        .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));
    mem_apb_wait #(.P_ADDR_START(32'h0000_0400), .P_DELAY(2)) u_s1 (
        .PCLK(pclk), .PRESETn(prst_n), .PSEL(psel[1]), .PADDR(paddr), .PENABLE(penable),
        .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));
    mem_apb_wait #(.P_ADDR_START(32'h0000_0800), .P_DELAY(3)) u_s2 (
        .PCLK(pclk), .PRESETn(prst_n), .PSEL(psel[2]), .PADDR(paddr), .PENABLE(penable),
        .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));
    mem_apb_wait #(.P_ADDR_START(32'h0000_0C00), .P_DELAY(5)) u_s3 (
        .PCLK(pclk), .PRESETn(prst_n), .PSEL(psel[3]), .PADDR(paddr), .PENABLE(penable),
        .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata[3]), .PREADY(pready[3]), .PSLVERR(pslverr[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit exp_err(input int s, input logic [31:0] a);
        logic [31:0] o;
        o = a - base[s];
        return (o >= 32'(SIZE)) || (a[1:0] != 2'b00);
    endfunction

    function automatic int widx(input int s, input logic [31:0] a);
        return int'(((a - base[s]) >> 2) & 32'hFF);
    endfunction

    // One complete transfer; must be called at posedge+1 so back-to-back calls leave no idle cycle.
    task automatic do_xfer(input int s, input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] st, output logic [31:0] rd, output logic er);
        int n;
        bit quiet_bad;
        bit e;
        int w;
        e = exp_err(s, a);
        w = widx(s, a);
        psel = '0; psel[s] = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = a; pwdata = d; pstrb = st; pprot = 3'($urandom);
        quiet_bad = 1'b0;
        @(negedge pclk);
        if (pready[s] || pslverr[s] || prdata[s] != 0) quiet_bad = 1'b1;
        @(posedge pclk); #1 penable = 1'b1;
        n = 0;
        while (n < 40) begin
            @(negedge pclk);
            n++;
            if (pready[s]) break;
            if (pslverr[s] || prdata[s] != 0) quiet_bad = 1'b1;
        end
        rd = prdata[s];
        er = pslverr[s];
        chk($sformatf("latency s%0d", s), n, dly[s] + 1);
        chk($sformatf("quiet_before_ready s%0d", s), quiet_bad, 0);
        chk($sformatf("slverr s%0d a=%h", s, a), er, e);
        if (!wr) begin
            if (e) chk($sformatf("rdata_on_err s%0d", s), rd, 0);
            else if (known[s][w]) chk($sformatf("rdata s%0d a=%h", s, a), rd, mem_m[s][w]);
        end else if (!e) begin
            for (int i = 0; i < 4; i++) if (st[i]) mem_m[s][w][i*8 +: 8] = d[i*8 +: 8];
            if (st == 4'hF) known[s][w] = 1'b1;
        end
        @(posedge pclk); #1;
        psel = '0; penable = 1'b0;
    endtask

    // Start a write and pull reset during access cycle k; the write must never land.
    task automatic do_abort(input int s, input logic [31:0] a, input logic [31:0] d,
                            input int k, input logic exp_rdy);
        psel = '0; psel[s] = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = a; pwdata = d; pstrb = 4'hF;
        @(posedge pclk); #1 penable = 1'b1;
        for (int i = 1; i < k; i++) begin
            @(posedge pclk); #1;
        end
        chk($sformatf("abort_pre_ready s%0d", s), pready[s], exp_rdy);
        prst_n = 1'b0;
        #1;
        chk($sformatf("abort_pready s%0d", s), pready[s], 0);
        chk($sformatf("abort_pslverr s%0d", s), pslverr[s], 0);
        chk($sformatf("abort_prdata s%0d", s), prdata[s], 0);
        psel = '0; penable = 1'b0;
        repeat (2) @(posedge pclk);
        #1 prst_n = 1'b1;
        @(posedge pclk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, v, a, d;
        logic        er;
        logic [3:0]  st;
        bit          bad;
        int          s, kind;

        prst_n = 1'b0; psel = '0; paddr = '0; penable = 1'b0; pwrite = 1'b0;
        pwdata = '0; pstrb = '0; pprot = '0;
        repeat (3) @(posedge pclk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_prdata s%0d", i), prdata[i], 0);
            chk($sformatf("reset_pready s%0d", i), pready[i], 0);
            chk($sformatf("reset_pslverr s%0d", i), pslverr[i], 0);
        end
        prst_n = 1'b1;
        @(posedge pclk); #1;

        do_xfer(0, 1, base[0], 32'hDEADBEEF, 4'hF, rd, er);
        do_xfer(0, 0, base[0], 0, 4'hF, rd, er);
        chk("deadbeef_read", rd, 32'hDEADBEEF);

        v = $urandom;
        do_xfer(2, 1, base[2] + 4, v, 4'hF, rd, er);
        do_xfer(2, 0, base[2] + 4, 0, 4'hF, rd, er);
        chk("delay3_read", rd, v);

        do_xfer(0, 1, base[0] + 8, 32'h11223344, 4'hF, rd, er);
        do_xfer(0, 1, base[0] + 8, 32'hAABBCCDD, 4'b0101, rd, er);
        do_xfer(0, 1, base[0] + 8, 32'h55555555, 4'b0000, rd, er);
        do_xfer(0, 0, base[0] + 8, 0, 4'hF, rd, er);
        chk("byte_lanes", rd, 32'h11BB33DD);

        do_xfer(1, 1, base[1], 32'h12345678, 4'hF, rd, er);
        do_xfer(1, 1, base[1] + 2, 32'hFFFFFFFF, 4'hF, rd, er);
        chk("misaligned_err", er, 1);
        do_xfer(1, 0, base[1], 0, 4'hF, rd, er);
        chk("misaligned_untouched", rd, 32'h12345678);
        do_xfer(1, 0, base[1] + SIZE, 0, 4'hF, rd, er);
        chk("range_err", er, 1);
        chk("range_prdata", rd, 0);
        do_xfer(1, 0, base[1] - 4, 0, 4'hF, rd, er);

        // PENABLE with no setup phase must not start a transfer.
        psel = 4'b0100; penable = 1'b1; pwrite = 1'b1; paddr = base[2] + 4; pwdata = ~v; pstrb = 4'hF;
        bad = 1'b0;
        repeat (6) begin
            @(negedge pclk);
            if (pready[2]) bad = 1'b1;
        end
        chk("penable_in_idle", bad, 0);
        @(posedge pclk); #1 psel = '0; penable = 1'b0;
        @(posedge pclk); #1;
        do_xfer(2, 0, base[2] + 4, 0, 4'hF, rd, er);

        do_xfer(3, 1, base[3] + 12, 32'hC0DE0003, 4'hF, rd, er);
        do_xfer(0, 1, base[0] + 12, 32'hC0DE0000, 4'hF, rd, er);
        do_abort(3, base[3] + 12, 32'hBAD00003, 3, 1'b0);
        do_abort(0, base[0] + 12, 32'hBAD00000, 1, 1'b1);
        do_xfer(3, 0, base[3] + 12, 0, 4'hF, rd, er);
        chk("abort_no_commit s3", rd, 32'hC0DE0003);
        do_xfer(0, 0, base[0] + 12, 0, 4'hF, rd, er);
        chk("abort_no_commit s0", rd, 32'hC0DE0000);

        for (int sl = 0; sl < 2; sl++) begin
            for (int o = 0; o <= 16; o += 4) begin
                do_xfer(sl, 1, base[sl] + o, $urandom, 4'hF, rd, er);
                do_xfer(sl, 0, base[sl] + o, 0, 4'hF, rd, er);
            end
            for (int o = 0; o <= 16; o += 4) do_xfer(sl, 1, base[sl] + o, $urandom, 4'hF, rd, er);
            for (int o = 0; o <= 16; o += 4) do_xfer(sl, 0, base[sl] + o, 0, 4'hF, rd, er);
        end

        for (int i = 0; i < 16; i++)
            for (int sl = 0; sl < 4; sl++) do_xfer(sl, 1, base[sl] + i * 4, $urandom, 4'hF, rd, er);
        for (int t = 0; t < 200; t++) begin
            s = $urandom_range(0, 3);
            kind = $urandom_range(0, 5);
            case (kind)
                3:       a = base[s] + $urandom_range(0, 15) * 4 + $urandom_range(1, 3);
                4:       a = base[s] + SIZE + $urandom_range(0, 15) * 4;
                5:       a = base[s] - 4;
                default: a = base[s] + $urandom_range(0, 15) * 4;
            endcase
            d  = $urandom;
            st = 4'($urandom);
            do_xfer(s, 1'($urandom), a, d, st, rd, er);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
